// File: rtl/async_fifo_stage_if.sv
// Token link of the req/ack dataflow fabric: the consumer raises req, the
// producer answers with a one-cycle ack carrying data.
// Ports (via modports):
//   master - producer end: drives ack and data, observes req
//   slave  - consumer end: drives req, observes ack and data
interface async_fifo_stage_if #(
    parameter int data_width = 32
);
    logic                  req;
    logic                  ack;
    logic [data_width-1:0] data;

    modport master (input req, output ack, output data);
    modport slave  (output req, input ack, input data);
endinterface

// File: rtl/async_fifo_stage.sv
// Elastic req/ack FIFO stage used for path balancing between dataflow operators.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   l_if      - slave link: pulls tokens from the upstream operator (req_l/ack_l/din)
//   r_if      - master link: serves the downstream operator (req_r/ack_r/dout)
//   count     - occupancy 0..depth
// Optional macro ASYNC_FIFO_STATS_EN adds max_level (high-water mark of count)
// and drop_cnt (saturating count of ack_l pulses seen while req_l was low).
module async_fifo_stage #(
    parameter int data_width = 32,
    parameter int depth      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    async_fifo_stage_if.slave      l_if,
    async_fifo_stage_if.master     r_if,
    output logic [$clog2(depth):0] count
`ifdef ASYNC_FIFO_STATS_EN
    ,
    output logic [$clog2(depth):0] max_level,
    output logic [31:0]            drop_cnt
`endif
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] DEPTH_C = (aw + 1)'(depth);

    typedef enum logic { L_IDLE, L_REQ } l_state_t;
    typedef enum logic { R_IDLE, R_ACK } r_state_t;

    logic [data_width-1:0] mem [depth];

    l_state_t              l_state_q, l_state_d;
    r_state_t              r_state_q, r_state_d;
    logic                  req_l_q, req_l_d;
    logic                  ack_r_q, ack_r_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic [aw:0]           count_q, count_d;
    logic [aw-1:0]         wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  push;
    logic                  pop;

`ifdef ASYNC_FIFO_STATS_EN
    logic [aw:0]           max_level_q, max_level_d;
    logic [31:0]           drop_cnt_q, drop_cnt_d;
    logic                  drop;
`endif

    always_comb begin
        // An ack only counts while we are actually requesting.
        push = !rst && (l_state_q == L_REQ) && l_if.ack;
        // A pop needs a token already present before this edge.
        pop  = (r_state_q == R_IDLE) && r_if.req && (count_q != '0);

        l_state_d = l_state_q;
        r_state_d = r_state_q;
        req_l_d   = req_l_q;
        ack_r_d   = ack_r_q;
        dout_d    = dout_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        unique case (l_state_q)
            L_IDLE: begin
                if (count_q < DEPTH_C) begin
                    l_state_d = L_REQ;
                    req_l_d   = 1'b1;
                end
            end
            L_REQ: begin
                if (l_if.ack) begin
                    l_state_d = L_IDLE;
                    req_l_d   = 1'b0;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                end
            end
        endcase

        unique case (r_state_q)
            R_IDLE: begin
                if (pop) begin
                    r_state_d = R_ACK;
                    ack_r_d   = 1'b1;
                    dout_d    = mem[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                end
            end
            R_ACK: begin
                r_state_d = R_IDLE;
                ack_r_d   = 1'b0;
            end
        endcase

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

`ifdef ASYNC_FIFO_STATS_EN
        drop        = !rst && l_if.ack && !req_l_q;
        max_level_d = (count_d > max_level_q) ? count_d : max_level_q;
        drop_cnt_d  = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
`endif
    end

    // Storage is left uninitialised; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= l_if.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_state_q   <= L_IDLE;
            r_state_q   <= R_IDLE;
            req_l_q     <= 1'b0;
            ack_r_q     <= 1'b0;
            dout_q      <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef ASYNC_FIFO_STATS_EN
            max_level_q <= '0;
            drop_cnt_q  <= '0;
`endif
        end else begin
            l_state_q   <= l_state_d;
            r_state_q   <= r_state_d;
            req_l_q     <= req_l_d;
            ack_r_q     <= ack_r_d;
            dout_q      <= dout_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef ASYNC_FIFO_STATS_EN
            max_level_q <= max_level_d;
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign l_if.req  = req_l_q;
    assign r_if.ack  = ack_r_q;
    assign r_if.data = dout_q;
    assign count     = count_q;
`ifdef ASYNC_FIFO_STATS_EN
    assign max_level = max_level_q;
    assign drop_cnt  = drop_cnt_q;
`endif
endmodule
